seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the shared seven-segment encoder. Holds one 5-bit code per digit (bit4 = blank, bits3:0 = hex value) and drives the single encoder input with each digit's code in turn. Asserts the matching active-low digit select while that code is shown. A blanking guard between digits suppresses ghosting. Sits between the keypad/application logic (writer) and the encoder plus display pins.

---
 rtl/seg_pkg.sv | 24 ++
 rtl/seg_digit_regfile.sv | 35 +++
 rtl/seg_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;

  localparam int CODE_W = 5;
  localparam logic [CODE_W-1:0] CODE_BLANK = 5'h10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

  // Any code with the blank bit set is presented to the encoder as the canonical blank.
  function automatic logic [CODE_W-1:0] shown_code(input logic [CODE_W-1:0] code);
    logic [CODE_W-1:0] res;
    if (code[CODE_W-1]) begin
      res = CODE_BLANK;
    end else begin
      res = code;
    end
    return res;
  endfunction

endpackage

// File: rtl/seg_digit_regfile.sv
// Per-digit code storage: one write port, one asynchronous read port.
module seg_digit_regfile
  import seg_pkg::*;
#(
  parameter int NUM_DIG = 8,
  parameter int AW      = $clog2(NUM_DIG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [CODE_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [CODE_W-1:0] rd_data
);

  logic [CODE_W-1:0] mem_r [NUM_DIG];
  logic              wr_ok_s;

  // Addresses past the last digit are dropped rather than aliased.
  assign wr_ok_s = (32'(wr_addr) < 32'(NUM_DIG));
  assign rd_data = mem_r[rd_addr];

  // Digit storage, blanked on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIG; i++) begin
        mem_r[i] <= CODE_BLANK;
      end
    end else if (wr_en && wr_ok_s) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed digit scanner driving one shared seven-segment encoder,
// with an all-off guard interval between digits to suppress ghosting.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIG   = 8,
  parameter int CNT_MAX   = 50000,
  parameter int GUARD_CYC = 50,
  localparam int AW       = $clog2(NUM_DIG)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [CODE_W-1:0]  wr_data,
  output logic [CODE_W-1:0]  enc_data,
  output logic [NUM_DIG-1:0] sel_n,
  output logic               frame_tick
);

  localparam int CNT_TOP = (CNT_MAX > GUARD_CYC) ? CNT_MAX : GUARD_CYC;
  localparam int CW      = $clog2(CNT_TOP + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(CNT_MAX - 1);
  localparam logic [CW-1:0] GUARD_LAST = (GUARD_CYC > 0) ? CW'(GUARD_CYC - 1) : {CW{1'b0}};
  localparam logic [AW-1:0] IDX_LAST   = AW'(NUM_DIG - 1);
  localparam scan_state_e   SLOT_ENTRY = (GUARD_CYC > 0) ? GUARD : SHOW;

  scan_state_e        state_r, state_nxt_s;
  logic [AW-1:0]      idx_r, idx_nxt_s;
  logic [CW-1:0]      cnt_r, cnt_nxt_s;
  logic               tick_nxt_s;
  logic [CODE_W-1:0]  rd_code_s, enc_nxt_s;
  logic [NUM_DIG-1:0] sel_nxt_s;

  // Read with the upcoming index so outputs move on the same edge as idx.
  seg_digit_regfile #(.NUM_DIG(NUM_DIG), .AW(AW)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx_nxt_s),
    .rd_data (rd_code_s)
  );

  // Scan sequencing; dropping en overrides everything, including the frame pulse.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    cnt_nxt_s   = cnt_r;
    tick_nxt_s  = 1'b0;
    if (!en) begin
      state_nxt_s = IDLE;
      idx_nxt_s   = {AW{1'b0}};
      cnt_nxt_s   = {CW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          idx_nxt_s   = {AW{1'b0}};
          cnt_nxt_s   = {CW{1'b0}};
          state_nxt_s = SLOT_ENTRY;
        end
        GUARD: begin
          if (cnt_r == GUARD_LAST) begin
            cnt_nxt_s   = {CW{1'b0}};
            state_nxt_s = SHOW;
          end else begin
            cnt_nxt_s = cnt_r + CW'(1);
          end
        end
        SHOW: begin
          if (cnt_r == CNT_LAST) begin
            cnt_nxt_s   = {CW{1'b0}};
            state_nxt_s = SLOT_ENTRY;
            if (idx_r == IDX_LAST) begin
              idx_nxt_s  = {AW{1'b0}};
              tick_nxt_s = 1'b1;
            end else begin
              idx_nxt_s = idx_r + AW'(1);
            end
          end else begin
            cnt_nxt_s = cnt_r + CW'(1);
          end
        end
        default: begin
          state_nxt_s = IDLE;
          idx_nxt_s   = {AW{1'b0}};
          cnt_nxt_s   = {CW{1'b0}};
        end
      endcase
    end
  end

  // Output values for the state being entered.
  always_comb begin
    sel_nxt_s = {NUM_DIG{1'b1}};
    enc_nxt_s = CODE_BLANK;
    if (state_nxt_s == SHOW) begin
      sel_nxt_s[idx_nxt_s] = 1'b0;
      enc_nxt_s            = shown_code(rd_code_s);
    end else begin
      sel_nxt_s = {NUM_DIG{1'b1}};
      enc_nxt_s = CODE_BLANK;
    end
  end

  // State, counters and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      idx_r      <= {AW{1'b0}};
      cnt_r      <= {CW{1'b0}};
      enc_data   <= CODE_BLANK;
      sel_n      <= {NUM_DIG{1'b1}};
      frame_tick <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      idx_r      <= idx_nxt_s;
      cnt_r      <= cnt_nxt_s;
      enc_data   <= enc_nxt_s;
      sel_n      <= sel_nxt_s;
      frame_tick <= tick_nxt_s;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: 4-digit main instance plus a 6-digit,
// no-guard instance for out-of-range writes and the zero-guard path.
module tb_seg_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en, wr_en;
  logic [1:0] wr_addr;
  logic [4:0] wr_data;
  logic [4:0] enc_data;
  logic [3:0] sel_n;
  logic       frame_tick;

  logic       en6, wr_en6;
  logic [2:0] wr_addr6;
  logic [4:0] wr_data6;
  logic [4:0] enc_data6;
  logic [5:0] sel_n6;
  logic       frame_tick6;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       en;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [4:0] wr_data;
    logic [3:0] sel;
    logic [4:0] enc;
    logic       tick;
  } vec_t;

  vec_t vecs[$];

  seg_scan_ctrl #(.NUM_DIG(4), .CNT_MAX(4), .GUARD_CYC(1)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .enc_data   (enc_data),
    .sel_n      (sel_n),
    .frame_tick (frame_tick)
  );

  seg_scan_ctrl #(.NUM_DIG(6), .CNT_MAX(2), .GUARD_CYC(0)) u_dut6 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en6),
    .wr_en      (wr_en6),
    .wr_addr    (wr_addr6),
    .wr_data    (wr_data6),
    .enc_data   (enc_data6),
    .sel_n      (sel_n6),
    .frame_tick (frame_tick6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int n, input logic e, input logic we, input logic [1:0] wa,
                     input logic [4:0] wd, input logic [3:0] s, input logic [4:0] c,
                     input logic t);
    vec_t v;
    v.en = e; v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
    v.sel = s; v.enc = c; v.tick = t;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // en must already be high; cycle 0 is the first guard cycle after en is sampled.
  task automatic scan_blank(input string tag, input int ncyc);
    logic [3:0] es;
    int         ph, slot;
    for (int n = 0; n < ncyc; n++) begin
      step();
      ph   = n % 5;
      slot = (n / 5) % 4;
      es   = 4'hF;
      if (ph != 0) es[slot] = 1'b0;
      chk($sformatf("%s_sel_c%0d", tag, n), 32'(sel_n), 32'(es));
      chk($sformatf("%s_enc_c%0d", tag, n), 32'(enc_data), 32'h10);
      chk($sformatf("%s_tick_c%0d", tag, n), 32'(frame_tick), 32'((n % 20 == 0) && (n > 0)));
    end
  endtask

  initial begin
    logic [5:0] es6;
    int         slot6;

    rst_n = 1'b0; en = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 5'h00;
    en6 = 1'b0; wr_en6 = 1'b0; wr_addr6 = 3'd0; wr_data6 = 5'h00;
    step(); step();
    chk("rst_sel", 32'(sel_n), 32'hF);
    chk("rst_enc", 32'(enc_data), 32'h10);
    chk("rst_tick", 32'(frame_tick), 32'h0);
    chk("rst_sel6", 32'(sel_n6), 32'h3F);
    rst_n = 1'b1;
    step();
    chk("idle_sel", 32'(sel_n), 32'hF);

    // 6-digit instance: fill in range, then try addresses 6 and 7.
    for (int k = 0; k < 8; k++) begin
      wr_en6 = 1'b1; wr_addr6 = 3'(k); wr_data6 = (k < 6) ? 5'(k + 1) : 5'h0E;
      step();
    end
    wr_en6 = 1'b0;
    en6 = 1'b1;
    for (int n = 0; n <= 12; n++) begin
      step();
      slot6 = (n / 2) % 6;
      es6 = 6'h3F;
      es6[slot6] = 1'b0;
      chk($sformatf("g0_sel_c%0d", n), 32'(sel_n6), 32'(es6));
      chk($sformatf("g0_enc_c%0d", n), 32'(enc_data6), 32'(slot6 + 1));
      chk($sformatf("g0_tick_c%0d", n), 32'(frame_tick6), 32'(n == 12));
    end
    en6 = 1'b0;
    step();
    chk("g0_off_sel", 32'(sel_n6), 32'h3F);

    // Blank scan with no writes.
    en = 1'b1;
    scan_blank("blank", 41);
    en = 1'b0;
    step();
    chk("blank_off_sel", 32'(sel_n), 32'hF);
    chk("blank_off_enc", 32'(enc_data), 32'h10);

    // Table: load digits, scan, live rewrite of digit 1, en drop mid digit 2, restart.
    add(1, 0, 1, 2'd0, 5'h01, 4'hF, 5'h10, 0);
    add(1, 0, 1, 2'd1, 5'h02, 4'hF, 5'h10, 0);
    add(1, 0, 1, 2'd2, 5'h0A, 4'hF, 5'h10, 0);
    add(1, 0, 1, 2'd3, 5'h1F, 4'hF, 5'h10, 0);
    add(1, 1, 0, 2'd0, 5'h00, 4'hF, 5'h10, 0);
    add(4, 1, 0, 2'd0, 5'h00, 4'hE, 5'h01, 0);
    add(1, 1, 0, 2'd0, 5'h00, 4'hF, 5'h10, 0);
    add(1, 1, 0, 2'd0, 5'h00, 4'hD, 5'h02, 0);
    add(1, 1, 1, 2'd1, 5'h07, 4'hD, 5'h02, 0);
    add(2, 1, 0, 2'd0, 5'h00, 4'hD, 5'h07, 0);
    add(1, 1, 0, 2'd0, 5'h00, 4'hF, 5'h10, 0);
    add(2, 1, 0, 2'd0, 5'h00, 4'hB, 5'h0A, 0);
    add(2, 0, 0, 2'd0, 5'h00, 4'hF, 5'h10, 0);
    add(1, 1, 0, 2'd0, 5'h00, 4'hF, 5'h10, 0);
    add(4, 1, 0, 2'd0, 5'h00, 4'hE, 5'h01, 0);
    add(1, 1, 0, 2'd0, 5'h00, 4'hF, 5'h10, 0);
    add(4, 1, 0, 2'd0, 5'h00, 4'hD, 5'h07, 0);
    add(1, 1, 0, 2'd0, 5'h00, 4'hF, 5'h10, 0);
    add(4, 1, 0, 2'd0, 5'h00, 4'hB, 5'h0A, 0);
    add(1, 1, 0, 2'd0, 5'h00, 4'hF, 5'h10, 0);
    add(4, 1, 0, 2'd0, 5'h00, 4'h7, 5'h10, 0);
    add(1, 1, 0, 2'd0, 5'h00, 4'hF, 5'h10, 1);
    add(1, 1, 0, 2'd0, 5'h00, 4'hE, 5'h01, 0);
    foreach (vecs[i]) begin
      en = vecs[i].en; wr_en = vecs[i].wr_en;
      wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
      step();
      chk($sformatf("vec%0d_sel", i), 32'(sel_n), 32'(vecs[i].sel));
      chk($sformatf("vec%0d_enc", i), 32'(enc_data), 32'(vecs[i].enc));
      chk($sformatf("vec%0d_tick", i), 32'(frame_tick), 32'(vecs[i].tick));
    end
    wr_en = 1'b0;

    // Drop en on the very last cycle of digit 3: no frame pulse.
    for (int i = 0; i < 18; i++) step();
    chk("wrap_last_sel", 32'(sel_n), 32'h7);
    en = 1'b0;
    step();
    chk("wrap_off_sel", 32'(sel_n), 32'hF);
    chk("wrap_off_enc", 32'(enc_data), 32'h10);
    chk("wrap_off_tick", 32'(frame_tick), 32'h0);
    step();
    chk("wrap_off_tick2", 32'(frame_tick), 32'h0);

    // Async reset in the middle of digit 1.
    en = 1'b1;
    for (int i = 0; i < 7; i++) step();
    chk("pre_rst_sel", 32'(sel_n), 32'hD);
    chk("pre_rst_enc", 32'(enc_data), 32'h07);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_sel", 32'(sel_n), 32'hF);
    chk("async_rst_enc", 32'(enc_data), 32'h10);
    chk("async_rst_tick", 32'(frame_tick), 32'h0);
    step(); step();
    chk("held_rst_sel", 32'(sel_n), 32'hF);
    rst_n = 1'b1;
    scan_blank("post_rst", 41);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
